// File: rtl/pong_paddle_ctrl_pkg.sv
// Shared types and screen geometry for the Pong paddle controller.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    HOLD      = 2'd3
  } paddle_state_e;

  localparam int V_RES       = 480;
  localparam int PADDLE_H    = 60;
  localparam int POS_MAX_DEF = V_RES - PADDLE_H;

  // Both buttons together cancel out rather than favouring one direction.
  function automatic paddle_state_e decode_dir(input logic up, input logic down);
    case ({up, down})
      2'b10:   return MOVE_UP;
      2'b01:   return MOVE_DOWN;
      2'b11:   return HOLD;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl_if.sv
// Button/pause inputs and paddle status outputs between the board side and the paddle controller.
interface pong_paddle_ctrl_if #(
  parameter int POS_W = 10
);
  logic             btn_up;
  logic             btn_down;
  logic             freeze;
  logic             recenter;
  logic [POS_W-1:0] paddle_pos;
  logic             up_db;
  logic             down_db;
  logic             at_top;
  logic             at_bottom;

  modport master (
    output btn_up, btn_down, freeze, recenter,
    input  paddle_pos, up_db, down_db, at_top, at_bottom
  );

  modport slave (
    input  btn_up, btn_down, freeze, recenter,
    output paddle_pos, up_db, down_db, at_top, at_bottom
  );
endinterface

// File: rtl/pong_paddle_ctrl_debounce.sv
// Two-flop synchroniser plus tick-gated debounce counter for one raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db
);

  localparam int            CW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          raw_p0;
  logic          raw_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_p0 <= 1'b0;
      raw_p1 <= 1'b0;
      cnt    <= '0;
      db     <= 1'b0;
    end else begin
      raw_p0 <= raw;
      raw_p1 <= raw_p0;
      // A disagreement must persist for DEBOUNCE_TICKS consecutive ticks to flip db.
      if (tick) begin
        if (raw_p1 == db) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          db  <= ~db;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Debounced, rate-limited, bounded paddle Y position driven by up/down buttons on a 10 kHz timebase.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 200,
  parameter int MOVE_TICKS     = 50,
  parameter int STEP           = 1,
  parameter int POS_W          = 10,
  parameter int POS_MIN        = 0,
  parameter int POS_MAX        = POS_MAX_DEF,
  parameter int POS_INIT       = 210
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_10kHz,
  pong_paddle_ctrl_if.slave       bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_UP   = MOVE_UP;
  localparam logic [1:0] ST_DOWN = MOVE_DOWN;

  localparam int             MW     = $clog2(MOVE_TICKS + 1);
  localparam logic [MW-1:0]  M_LAST = MW'(MOVE_TICKS - 1);
  localparam logic [POS_W:0] MIN_X  = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0] MAX_X  = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0] STEP_X = (POS_W+1)'(STEP);

  // One extra bit keeps pos+STEP and the lower-bound test free of wrap-around.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos, input logic down);
    logic [POS_W:0] ext;
    ext = {1'b0, pos};
    if (down) begin
      ext = ext + STEP_X;
      if (ext > MAX_X) ext = MAX_X;
    end else begin
      if (ext < MIN_X + STEP_X) ext = MIN_X;
      else                      ext = ext - STEP_X;
    end
    return ext[POS_W-1:0];
  endfunction

  logic             ck_p0, ck_p1, ck_p2;
  logic [1:0]       warm;
  logic             tick;
  logic             up_db, down_db;
  logic [1:0]       state, nxt;
  logic [MW-1:0]    move_cnt;
  logic [POS_W-1:0] pos_q;

  // Timebase sync; warm gates tick until ck_p2 holds a genuinely sampled level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_p0 <= 1'b0;
      ck_p1 <= 1'b0;
      ck_p2 <= 1'b0;
      warm  <= 2'd0;
    end else begin
      ck_p0 <= clk_10kHz;
      ck_p1 <= ck_p0;
      ck_p2 <= ck_p1;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign tick = ck_p1 & ~ck_p2 & (warm == 2'd3);

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_up (
    .clk(clk), .rst(rst), .tick(tick), .raw(bus.btn_up), .db(up_db)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_down (
    .clk(clk), .rst(rst), .tick(tick), .raw(bus.btn_down), .db(down_db)
  );

  assign nxt = decode_dir(up_db, down_db);

  // Motion: recenter wins over everything, then state change, then a tick-gated step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      move_cnt <= '0;
      pos_q    <= POS_W'(POS_INIT);
    end else begin
      state <= nxt;
      if (bus.recenter) begin
        pos_q    <= POS_W'(POS_INIT);
        move_cnt <= '0;
      end else if (nxt != state) begin
        move_cnt <= '0;
      end else if (tick && !bus.freeze && (state == ST_UP || state == ST_DOWN)) begin
        if (move_cnt == M_LAST) begin
          move_cnt <= '0;
          pos_q    <= step_pos(pos_q, state == ST_DOWN);
        end else begin
          move_cnt <= move_cnt + MW'(1);
        end
      end
    end
  end

  assign bus.paddle_pos = pos_q;
  assign bus.up_db      = up_db;
  assign bus.down_db    = down_db;
  assign bus.at_top     = (pos_q == POS_W'(POS_MIN));
  assign bus.at_bottom  = (pos_q == POS_W'(POS_MAX));

endmodule
